// File: rtl/mem_arbiter.sv
// Two-port arbiter (instruction fetch / data) in front of a fixed-latency main memory.
// One transaction in flight at a time; simultaneous requests are served round-robin.
module mem_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic [31:0] mem_addr,
  output logic [64:0] mem_edit,
  input  logic [31:0] mem_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic {PORT_IF = 1'b0, PORT_DM = 1'b1} port_e;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  port_e       port_q, port_d;
  port_e       last_grant_q, last_grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;
  logic        if_ready_q, if_ready_d;
  logic        dm_ready_q, dm_ready_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [64:0] mem_edit_q, mem_edit_d;

  port_e       grant;
  logic        grant_we;
  logic [31:0] grant_addr;

  // On a tie the data port wins unless it was the port served last.
  assign grant      = (dm_req && (!if_req || last_grant_q == PORT_IF)) ? PORT_DM : PORT_IF;
  assign grant_we   = (grant == PORT_DM) && dm_we;
  assign grant_addr = (grant == PORT_DM) ? dm_addr : if_addr;

  always_comb begin
    // NOTE: every _d signal gets a default before the case, so no path can infer a latch.
    state_d      = state_q;
    port_d       = port_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_ready_d   = 1'b0;
    dm_ready_d   = 1'b0;
    mem_addr_d   = 32'd0;
    mem_edit_d   = 65'd0;

    unique case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          state_d      = ACCESS;
          port_d       = grant;
          last_grant_d = grant;
          we_d         = grant_we;
          cnt_d        = CNT_LOAD;
          mem_addr_d   = grant_addr;
          // The write strobe is only presented during the first ACCESS cycle.
          if (grant_we) mem_edit_d = {1'b1, dm_addr, dm_wdata};
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (port_q == PORT_DM) begin
            dm_ready_d = 1'b1;
            if (!we_q) dm_rdata_d = mem_data;
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_data;
          end
        end else begin
          cnt_d      = cnt_q - 4'd1;
          mem_addr_d = mem_addr_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      port_q       <= PORT_IF;
      last_grant_q <= PORT_IF;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      if_rdata_q   <= 32'd0;
      dm_rdata_q   <= 32'd0;
      if_ready_q   <= 1'b0;
      dm_ready_q   <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_edit_q   <= 65'd0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_ready_q   <= if_ready_d;
      dm_ready_q   <= dm_ready_d;
      mem_addr_q   <= mem_addr_d;
      mem_edit_q   <= mem_edit_d;
    end
  end

  assign if_rdata = if_rdata_q;
  assign if_ready = if_ready_q;
  assign dm_rdata = dm_rdata_q;
  assign dm_ready = dm_ready_q;
  assign mem_addr = mem_addr_q;
  assign mem_edit = mem_edit_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance at LATENCY=1, one at LATENCY=3, directed steps
// followed by random traffic checked against a transaction-level model.
module tb_mem_arbiter;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset    [2];
  logic        if_req   [2];
  logic [31:0] if_addr  [2];
  logic [31:0] if_rdata [2];
  logic        if_ready [2];
  logic        dm_req   [2];
  logic        dm_we    [2];
  logic [31:0] dm_addr  [2];
  logic [31:0] dm_wdata [2];
  logic [31:0] dm_rdata [2];
  logic        dm_ready [2];
  logic [31:0] mem_addr [2];
  logic [64:0] mem_edit [2];
  logic [31:0] mem_data [2];

  mem_arbiter #(.LATENCY(LAT0)) u_dut_l1 (
    .clk(clk), .reset(reset[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_ready(if_ready[0]),
    .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
    .dm_rdata(dm_rdata[0]), .dm_ready(dm_ready[0]),
    .mem_addr(mem_addr[0]), .mem_edit(mem_edit[0]), .mem_data(mem_data[0])
  );

  mem_arbiter #(.LATENCY(LAT1)) u_dut_l3 (
    .clk(clk), .reset(reset[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_ready(if_ready[1]),
    .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
    .dm_rdata(dm_rdata[1]), .dm_ready(dm_ready[1]),
    .mem_addr(mem_addr[1]), .mem_edit(mem_edit[1]), .mem_data(mem_data[1])
  );

  // Unwritten memory words read back as a recognisable address-derived pattern.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return 32'hC0DE_0000 | {26'd0, a[5:0]};
  endfunction

  // Main-memory environment: writes land at the clock edge, read data settles mid-cycle.
  bit [31:0] env_mem [2][64];
  bit        env_wr  [2][64];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_edit[d][64]) begin
        env_mem[d][mem_edit[d][37:32]] <= mem_edit[d][31:0];
        env_wr[d][mem_edit[d][37:32]]  <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      mem_data[d] <= env_wr[d][mem_addr[d][5:0]] ? env_mem[d][mem_addr[d][5:0]] : dflt(mem_addr[d]);
  end

  // Reference memory contents as the model expects them.
  bit [31:0] mdl_mem [2][64];
  bit        mdl_wr  [2][64];

  function automatic logic [31:0] mdl_rd(input int d, input logic [31:0] a);
    return mdl_wr[d][a[5:0]] ? mdl_mem[d][a[5:0]] : dflt(a);
  endfunction

  task automatic mdl_write(input int d, input logic [31:0] a, input logic [31:0] v);
    mdl_mem[d][a[5:0]] = v;
    mdl_wr[d][a[5:0]]  = 1'b1;
  endtask

  int n_assert = 0;
  int n_fail   = 0;
  int n;
  int m;
  logic [3:0] ord;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input int d, input string tag, input logic e_ifr, input logic e_dmr,
                          input logic [31:0] e_ifrd, input logic [31:0] e_dmrd,
                          input logic [31:0] e_maddr, input logic [64:0] e_edit);
    check({tag, ".if_ready"}, 65'(if_ready[d]), 65'(e_ifr));
    check({tag, ".dm_ready"}, 65'(dm_ready[d]), 65'(e_dmr));
    check({tag, ".if_rdata"}, 65'(if_rdata[d]), 65'(e_ifrd));
    check({tag, ".dm_rdata"}, 65'(dm_rdata[d]), 65'(e_dmrd));
    check({tag, ".mem_addr"}, 65'(mem_addr[d]), 65'(e_maddr));
    check({tag, ".mem_edit"}, mem_edit[d], e_edit);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Ends on the falling edge where reset is released; the next rising edge samples requests.
  task automatic do_reset(input int d);
    tick();
    reset[d]  = 1'b1;
    if_req[d] = 1'b0;
    dm_req[d] = 1'b0;
    dm_we[d]  = 1'b0;
    tick();
    reset[d]  = 1'b0;
  endtask

  // Random traffic against a transaction-level model: a grant at cycle g drives the
  // address during cycles g+1..g+lat and completes in cycle g+lat+1.
  task automatic random_run(input int d, input int lat, input int ncyc);
    int          g;
    int          k;
    bit          busy;
    bit          last_dm;
    bit          t_dm;
    bit          t_we;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic [31:0] e_ifrd;
    logic [31:0] e_dmrd;
    logic [31:0] e_maddr;
    logic [64:0] e_edit;
    logic        e_ifr;
    logic        e_dmr;
    do_reset(d);
    g = 0; busy = 1'b0; last_dm = 1'b0; e_ifrd = 32'd0; e_dmrd = 32'd0;
    t_dm = 1'b0; t_we = 1'b0; t_addr = 32'd0; t_wdata = 32'd0;
    for (int c = 0; c < ncyc; c++) begin
      e_ifr = 1'b0; e_dmr = 1'b0; e_maddr = 32'd0; e_edit = 65'd0;
      if (busy) begin
        k = c - g;
        if (k >= 1 && k <= lat) e_maddr = t_addr;
        if (k == 1 && t_we) e_edit = {1'b1, t_addr, t_wdata};
        if (k == lat + 1) begin
          if (t_dm) begin
            e_dmr = 1'b1;
            if (!t_we) e_dmrd = mdl_rd(d, t_addr);
          end else begin
            e_ifr  = 1'b1;
            e_ifrd = mdl_rd(d, t_addr);
          end
        end
      end
      chk_outs(d, "rand", e_ifr, e_dmr, e_ifrd, e_dmrd, e_maddr, e_edit);

      if (e_ifr) if_req[d] = 1'b0;
      if (e_dmr) begin dm_req[d] = 1'b0; dm_we[d] = 1'b0; end
      if (!if_req[d] && $urandom_range(0, 2) == 0) begin
        if_req[d]  = 1'b1;
        if_addr[d] = {26'd0, 6'($urandom)};
      end
      if (!dm_req[d] && $urandom_range(0, 2) == 0) begin
        dm_req[d]   = 1'b1;
        dm_we[d]    = 1'($urandom);
        dm_addr[d]  = {26'd0, 6'($urandom)};
        dm_wdata[d] = $urandom;
      end

      if ((!busy || (c - g) >= lat + 2) && (if_req[d] || dm_req[d])) begin
        t_dm    = dm_req[d] && (!if_req[d] || !last_dm);
        last_dm = t_dm;
        busy    = 1'b1;
        g       = c;
        t_addr  = t_dm ? dm_addr[d] : if_addr[d];
        t_we    = t_dm && dm_we[d];
        t_wdata = dm_wdata[d];
        if (t_we) mdl_write(d, t_addr, t_wdata);
      end
      tick();
    end
    if_req[d] = 1'b0;
    dm_req[d] = 1'b0;
    dm_we[d]  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; if_req[d] = 1'b0; if_addr[d] = 32'd0;
      dm_req[d] = 1'b0; dm_we[d] = 1'b0; dm_addr[d] = 32'd0; dm_wdata[d] = 32'd0;
    end
    tick();
    tick();
    chk_outs(0, "reset0", 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 65'd0);
    chk_outs(1, "reset1", 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 65'd0);
    reset[0] = 1'b0;
    reset[1] = 1'b0;

    // Write of 2 to address 1 at LATENCY=1.
    dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 32'd1; dm_wdata[0] = 32'd2;
    mdl_write(0, 32'd1, 32'd2);
    tick(); chk_outs(0, "wr.c1", 1'b0, 1'b0, 32'd0, 32'd0, 32'd1, 65'h1_0000_0001_0000_0002);
    tick(); chk_outs(0, "wr.c2", 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 65'd0);
    dm_req[0] = 1'b0; dm_we[0] = 1'b0;
    tick(); chk_outs(0, "wr.c3", 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 65'd0);

    // Read back address 1.
    dm_req[0] = 1'b1; dm_addr[0] = 32'd1;
    tick(); chk_outs(0, "rd.c1", 1'b0, 1'b0, 32'd0, 32'd0, 32'd1, 65'd0);
    tick(); chk_outs(0, "rd.c2", 1'b0, 1'b1, 32'd0, 32'd2, 32'd0, 65'd0);
    dm_req[0] = 1'b0;
    tick(); chk_outs(0, "rd.c3", 1'b0, 1'b0, 32'd0, 32'd2, 32'd0, 65'd0);

    // Both ports held after reset: completions must alternate D, I, D, I.
    do_reset(0);
    if_req[0] = 1'b1; if_addr[0] = 32'h20;
    dm_req[0] = 1'b1; dm_addr[0] = 32'h21; dm_we[0] = 1'b0;
    n = 0; ord = 4'd0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      check("rr.exclusive", 65'(if_ready[0] & dm_ready[0]), 65'd0);
      if (if_ready[0] || dm_ready[0]) begin
        ord = {ord[2:0], dm_ready[0]};
        n++;
      end
      if (dm_ready[0]) check("rr.dm_rdata", 65'(dm_rdata[0]), 65'(dflt(32'h21)));
      if (if_ready[0]) check("rr.if_rdata", 65'(if_rdata[0]), 65'(dflt(32'h20)));
    end
    if_req[0] = 1'b0; dm_req[0] = 1'b0;
    check("rr.count", 65'(n), 65'd4);
    check("rr.order", 65'(ord), 65'(4'b1010));
    tick(); tick();

    // Data request dropped while its access is in progress.
    dm_req[0] = 1'b1; dm_addr[0] = 32'd3; dm_we[0] = 1'b0;
    tick();
    dm_req[0] = 1'b0;
    check("drop.mem_addr", 65'(mem_addr[0]), 65'd3);
    tick();
    check("drop.ready", 65'(dm_ready[0]), 65'd1);
    check("drop.rdata", 65'(dm_rdata[0]), 65'(dflt(32'd3)));
    n = 0; m = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (dm_ready[0] || if_ready[0]) n++;
      if (mem_addr[0] != 32'd0) m++;
    end
    check("drop.extra_ready", 65'(n), 65'd0);
    check("drop.extra_access", 65'(m), 65'd0);

    // Fetch at LATENCY=3: address held three cycles, ready in the fourth.
    if_req[1] = 1'b1; if_addr[1] = 32'h10;
    for (int c = 1; c <= 3; c++) begin
      tick(); chk_outs(1, "l3.access", 1'b0, 1'b0, 32'd0, 32'd0, 32'h10, 65'd0);
    end
    tick(); chk_outs(1, "l3.resp", 1'b1, 1'b0, 32'hC0DE_0010, 32'd0, 32'd0, 65'd0);
    if_req[1] = 1'b0;
    tick(); chk_outs(1, "l3.after", 1'b0, 1'b0, 32'hC0DE_0010, 32'd0, 32'd0, 65'd0);

    // Reset arriving while a write strobe is on the bus.
    dm_req[1] = 1'b1; dm_we[1] = 1'b1; dm_addr[1] = 32'd5; dm_wdata[1] = 32'hDEAD_BEEF;
    tick(); chk_outs(1, "rst.pre", 1'b0, 1'b0, 32'hC0DE_0010, 32'd0, 32'd5,
                     {1'b1, 32'd5, 32'hDEAD_BEEF});
    #2;
    reset[1] = 1'b1; dm_req[1] = 1'b0; dm_we[1] = 1'b0;
    #1;
    chk_outs(1, "rst.async", 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 65'd0);
    tick();
    reset[1] = 1'b0;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (dm_ready[1] || if_ready[1] || mem_edit[1][64]) n++;
    end
    check("rst.no_activity", 65'(n), 65'd0);
    dm_req[1] = 1'b1; dm_addr[1] = 32'd7;
    for (int c = 1; c <= 3; c++) begin
      tick(); chk_outs(1, "rst.next_access", 1'b0, 1'b0, 32'd0, 32'd0, 32'd7, 65'd0);
    end
    tick(); chk_outs(1, "rst.next_resp", 1'b0, 1'b1, 32'd0, dflt(32'd7), 32'd0, 65'd0);
    dm_req[1] = 1'b0;
    tick();

    random_run(0, LAT0, 600);
    random_run(1, LAT1, 600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: LATENCY, default 1, cycles from address presentation to valid mem_data (legal range 1..15).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 if_req  input  1  instruction-fetch read request, level, held until if_ready.
REQ-005 if_addr  input  32  fetch word address.
REQ-006 if_rdata  output  32  fetch read data, registered.
REQ-007 if_ready  output  1  one-cycle completion pulse for fetch port.
REQ-008 dm_req  input  1  data-port request, level, held until dm_ready.
REQ-009 dm_we  input  1  data-port write enable (1 = write, 0 = read).
REQ-010 dm_addr  input  32  data word address.
REQ-011 dm_wdata  input  32  data-port write data.
REQ-012 dm_rdata  output  32  data-port read data, registered.
REQ-013 dm_ready  output  1  one-cycle completion pulse for data port.
REQ-014 mem_addr  output  32  read address to main memory.
REQ-015 mem_edit  output  65  write bundle to main memory: [64] write strobe, [63:32] address, [31:0] data.
REQ-016 mem_data  input  32  read data from main memory.

Function
REQ-017 FSM states IDLE, ACCESS, RESP; one transaction in flight at a time; addresses passed unchanged (word addressing).
REQ-018 IDLE: sample requests each edge; if any pending, latch port, address, we, wdata, go ACCESS; else stay IDLE.
REQ-019 Arbitration: one request pending -> grant it; both pending -> grant the port not granted last (round-robin via last_grant register).
REQ-020 ACCESS lasts exactly LATENCY cycles, tracked by 4-bit down-counter loaded with LATENCY-1 at grant; exit to RESP when counter is 0.
REQ-021 During ACCESS mem_addr = latched address; outside ACCESS mem_addr = 0.
REQ-022 Write: mem_edit = {1, addr, wdata} in first ACCESS cycle only; all other cycles mem_edit = 0.
REQ-023 Read: mem_data captured into granted port's rdata register at the edge leaving ACCESS.
REQ-024 RESP lasts one cycle: granted port's ready = 1, other ready = 0; requests not sampled; next state IDLE.
REQ-025 Latency: request first seen in IDLE at cycle 0 -> ready high in cycle LATENCY+1; back-to-back same-port throughput one transaction per LATENCY+2 cycles.
REQ-026 rdata registers hold value until next read completion on that port; dm_rdata unchanged by writes.
REQ-027 Request dropped during ACCESS: transaction still completes, ready still pulses.
REQ-028 if_ready and dm_ready never high in same cycle; each pulse exactly one cycle.

Reset
REQ-029 reset asserted: state IDLE, counter 0, last_grant = fetch (data port wins first tie), if_rdata = dm_rdata = 0, if_ready = dm_ready = 0, mem_addr = 0, mem_edit = 0, all immediately without clock.
REQ-030 Reset during ACCESS aborts transaction; no ready pulse; write strobe removed immediately.
REQ-031 After reset release, first sampling edge is the first rising clk edge with reset low.

Verification
REQ-032 LATENCY=1, dm_req=1, dm_we=1, dm_addr=1, dm_wdata=2 -> mem_edit = 0x1_00000001_00000002 for one cycle, dm_ready pulses 2 cycles after request.
REQ-033 After REQ-032, dm read addr 1 with memory model returning 2 -> dm_rdata = 0x00000002 with dm_ready pulse; if_rdata unchanged 0.
REQ-034 if_req and dm_req asserted same cycle after reset, held -> grant order DM, IF, DM, IF; never two grants to same port while other waits.
REQ-035 LATENCY=3, if_req addr 0x10 -> mem_addr = 0x10 for exactly 3 cycles, if_ready in cycle 4, mem_edit stays 0.
REQ-036 Reset pulsed mid-ACCESS of a write -> mem_edit[64] low at once, no dm_ready, outputs at reset values, next request served normally.
REQ-037 dm_req dropped after grant -> dm_ready still pulses once; no second transaction issued.
